uart_tx_scheduler: RTL and testbench

Shares one UART transmit line among NUM_REQ byte producers. Each producer offers a byte with a valid/ready handshake. A round-robin arbiter picks one producer, and the block serializes the byte as a frame: start bit, 8 data bits LSB first, optional parity bit, stop bit. Frames are paced by the system baud_tick. The block is the transmit-side counterpart of the receiver FSM and sits between the command/status sources and the tx pad.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/uart_tx_scheduler.sv | 147 ++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, transmit scheduler states and
// the parity helper used by the transmit path.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_BIT_CNT_W = $clog2(UART_DATA_BITS);

  // Same explicit-encoding style as the receiver state enum.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } tx_sched_state_t;

  // Even parity is plain XOR-reduce; odd parity inverts it.
  function automatic logic frame_parity(input logic [UART_DATA_BITS-1:0] data,
                                        input logic                      odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The search starts one past the last
// winner and wraps, so the most recently served requester has lowest
// priority. Grant is suppressed unless enable_i is high; any_req_o is not.
module rr_arbiter #(
  parameter int  N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_grant_i,
  input  logic          enable_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          any_req_o
);

  // Rotating priority search from last_grant_i+1, first hit wins.
  always_comb begin : arb_search
    int   idx;
    logic found;
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    any_req_o = |req_i;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_grant_i) + k) % N;
      if (!found && req_i[IW'(idx)]) begin
        found     = 1'b1;
        gnt_idx_o = IW'(idx);
      end
    end
    if (enable_i && found) begin
      gnt_o[gnt_idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART tx line among NUM_REQ byte producers. A round-robin
// arbiter picks a producer, its byte is latched, and the frame
// (start, 8 data LSB first, optional parity, stop) is paced by baud_tick.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | line idle high, ticks ignored, grants any pending request
// ARM    | byte latched, waiting for first tick so start bit is full
// START  | driving start bit (0)
// DATA   | driving byte[bit_cnt], LSB first
// PARITY | driving parity bit (only reachable with PARITY_EN)
// STOP   | driving stop bit (1); tick ends frame, may grant back-to-back
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int  NUM_REQ    = 4,
  parameter bit  PARITY_EN  = 1'b1,
  parameter bit  PARITY_ODD = 1'b0,
  localparam int GW         = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              nrst,
  input  logic                              baud_tick,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [UART_DATA_BITS*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              tx_o,
  output logic                              busy,
  output logic [GW-1:0]                     grant_id,
  output logic                              frame_done
);

  tx_sched_state_t             state_q, state_d;
  logic [UART_DATA_BITS-1:0]   byte_q, byte_d;
  logic [UART_BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]               last_grant_q, last_grant_d;
  logic [GW-1:0]               grant_id_q, grant_id_d;
  logic                        tx_q, tx_d;

  logic                        arb_en;
  logic [NUM_REQ-1:0]          arb_gnt;
  logic [GW-1:0]               arb_idx;
  logic                        arb_any;
  logic                        grant_fire;
  logic                        stop_tick;

  assign stop_tick  = (state_q == STOP) && baud_tick;
  // Grants only in IDLE or on the tick that ends the stop bit; held off
  // while in reset so no byte is offered-and-dropped.
  assign arb_en     = nrst && ((state_q == IDLE) || stop_tick);
  assign grant_fire = arb_en && arb_any;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .enable_i     (arb_en),
    .gnt_o        (arb_gnt),
    .gnt_idx_o    (arb_idx),
    .any_req_o    (arb_any)
  );

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= IDLE;
      byte_q       <= '0;
      bit_cnt_q    <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      grant_id_q   <= '0;
      tx_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      byte_q       <= byte_d;
      bit_cnt_q    <= bit_cnt_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      tx_q         <= tx_d;
    end
  end

  // Next-state logic: advance one bit per baud_tick, latch byte on grant.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    byte_d       = byte_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;

    if (grant_fire) begin
      byte_d       = req_data[UART_DATA_BITS*int'(arb_idx) +: UART_DATA_BITS];
      last_grant_d = arb_idx;
      grant_id_d   = arb_idx;
    end

    unique case (state_q)
      IDLE: begin
        if (grant_fire) state_d = ARM;
      end
      ARM: begin
        if (baud_tick) state_d = START;
      end
      START: begin
        if (baud_tick) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q == UART_BIT_CNT_W'(UART_DATA_BITS - 1)) begin
            state_d = PARITY_EN ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (baud_tick) state_d = STOP;
      end
      STOP: begin
        // Back-to-back frames go straight to START: no extra idle bit.
        if (baud_tick) state_d = grant_fire ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: tx level for the upcoming state, busy, handshake and done.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = byte_q[bit_cnt_d];
      PARITY:  tx_d = frame_parity(byte_q, PARITY_ODD);
      default: tx_d = 1'b1;
    endcase
    busy       = (state_q != IDLE) || grant_fire;
    frame_done = nrst && stop_tick;
    req_ready  = arb_gnt;
  end

  assign tx_o     = tx_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler. Three instances share stimulus:
// even parity, odd parity, and no parity.
module tb_uart_tx_scheduler;

  logic        clk;
  logic        nrst;
  logic        baud_tick;
  logic [3:0]  req_valid;
  logic [31:0] req_data;

  logic [3:0]  rdy0, rdy1, rdy2;
  logic        tx0, tx1, tx2;
  logic        busy0, busy1, busy2;
  logic [1:0]  gid0, gid1, gid2;
  logic        fd0, fd1, fd2;

  int errors = 0;
  int checks = 0;

  uart_tx_scheduler #(.NUM_REQ(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut_even (
    .clk(clk), .nrst(nrst), .baud_tick(baud_tick), .req_valid(req_valid),
    .req_data(req_data), .req_ready(rdy0), .tx_o(tx0), .busy(busy0),
    .grant_id(gid0), .frame_done(fd0));

  uart_tx_scheduler #(.NUM_REQ(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_dut_odd (
    .clk(clk), .nrst(nrst), .baud_tick(baud_tick), .req_valid(req_valid),
    .req_data(req_data), .req_ready(rdy1), .tx_o(tx1), .busy(busy1),
    .grant_id(gid1), .frame_done(fd1));

  uart_tx_scheduler #(.NUM_REQ(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut_nopar (
    .clk(clk), .nrst(nrst), .baud_tick(baud_tick), .req_valid(req_valid),
    .req_data(req_data), .req_ready(rdy2), .tx_o(tx2), .busy(busy2),
    .grant_id(gid2), .frame_done(fd2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         req;
    logic [7:0] data;
    logic       par_even;
    logic       par_odd;
    logic       tick_at_grant;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: inputs applied after the falling edge, outputs sampled 1ns later.
  task automatic cycle(input logic t, input logic [3:0] v);
    @(negedge clk);
    baud_tick = t;
    req_valid = v;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst      = 1'b0;
    baud_tick = 1'b0;
    req_valid = 4'h0;
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    #1;
  endtask

  // Expected line level at bit position k of a frame (k past the end = idle).
  function automatic logic exp_bit(input logic [7:0] d, input int k,
                                   input bit has_par, input logic par);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9 && has_par) return par;
    return 1'b1;
  endfunction

  initial begin
    int         n;
    logic [3:0] prev;
    int         gid_pend;
    int         order[5];
    vec_t       v;

    vecs[0] = '{req: 0, data: 8'hA5, par_even: 1'b0, par_odd: 1'b1, tick_at_grant: 1'b0};
    vecs[1] = '{req: 1, data: 8'h00, par_even: 1'b0, par_odd: 1'b1, tick_at_grant: 1'b1};
    vecs[2] = '{req: 2, data: 8'hFF, par_even: 1'b0, par_odd: 1'b1, tick_at_grant: 1'b0};
    vecs[3] = '{req: 3, data: 8'h01, par_even: 1'b1, par_odd: 1'b0, tick_at_grant: 1'b0};
    vecs[4] = '{req: 2, data: 8'h80, par_even: 1'b1, par_odd: 1'b0, tick_at_grant: 1'b1};
    vecs[5] = '{req: 1, data: 8'h07, par_even: 1'b1, par_odd: 1'b0, tick_at_grant: 1'b0};
    order = '{0, 1, 2, 3, 0};

    nrst      = 1'b0;
    baud_tick = 1'b0;
    req_valid = 4'h0;
    req_data  = 32'h0;

    do_reset();
    chk("rst_tx", tx0, 1'b1);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_ready", rdy0, 4'h0);
    chk("rst_done", fd0, 1'b0);
    chk("rst_gid", gid0, 2'd0);
    chk("rst_tx_nopar", tx2, 1'b1);

    // Single frames from the vector table, all three parity variants.
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      req_data[8*v.req +: 8] = v.data;
      cycle(v.tick_at_grant, 4'(1 << v.req));
      chk("grant_ready_even", rdy0, 32'(1 << v.req));
      chk("grant_ready_odd", rdy1, 32'(1 << v.req));
      chk("grant_ready_nopar", rdy2, 32'(1 << v.req));
      chk("grant_busy", busy0, 1'b1);
      cycle(1'b0, 4'h0);
      chk("ready_one_cycle", rdy0, 4'h0);
      chk("arm_tx", tx0, 1'b1);
      chk("arm_gid", gid0, 32'(v.req));
      for (int k = 0; k <= 11; k++) begin
        cycle(1'b1, 4'h0);
        chk("done_even", fd0, 32'(k == 11));
        chk("done_odd", fd1, 32'(k == 11));
        chk("done_nopar", fd2, 32'(k == 10));
        cycle(1'b0, 4'h0);
        chk("tx_even", tx0, exp_bit(v.data, k, 1'b1, v.par_even));
        chk("tx_odd", tx1, exp_bit(v.data, k, 1'b1, v.par_odd));
        chk("tx_nopar", tx2, exp_bit(v.data, k, 1'b0, 1'b0));
        cycle(1'b0, 4'h0);
      end
      chk("idle_busy_even", busy0, 1'b0);
      chk("idle_busy_nopar", busy2, 1'b0);
    end

    // Back-to-back: req1 and req2 together, req2 granted on req1's stop tick.
    do_reset();
    req_data = {8'h00, 8'h81, 8'h3C, 8'h00};
    cycle(1'b0, 4'b0110);
    chk("b2b_first_ready", rdy0, 4'b0010);
    cycle(1'b0, 4'b0100);
    chk("b2b_first_gid", gid0, 2'd1);
    chk("b2b_no_grant_arm", rdy0, 4'h0);
    for (int k = 0; k <= 10; k++) begin
      cycle(1'b1, 4'b0100);
      chk("b2b_wait_ready", rdy0, 4'h0);
      cycle(1'b0, 4'b0100);
      chk("b2b_tx1", tx0, exp_bit(8'h3C, k, 1'b1, 1'b0));
    end
    cycle(1'b1, 4'b0100);
    chk("b2b_done1", fd0, 1'b1);
    chk("b2b_second_ready", rdy0, 4'b0100);
    chk("b2b_busy", busy0, 1'b1);
    cycle(1'b0, 4'h0);
    chk("b2b_start_no_gap", tx0, 1'b0);
    chk("b2b_second_gid", gid0, 2'd2);
    chk("b2b_busy2", busy0, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b1, 4'h0);
      cycle(1'b0, 4'h0);
      chk("b2b_tx2", tx0, exp_bit(8'h81, k, 1'b1, 1'b0));
    end
    cycle(1'b1, 4'h0);
    chk("b2b_done2", fd0, 1'b1);
    cycle(1'b0, 4'h0);
    chk("b2b_end_busy", busy0, 1'b0);
    chk("b2b_end_tx", tx0, 1'b1);

    // Round robin: all four valid continuously for five frames.
    do_reset();
    req_data = 32'h44332211;
    n        = 0;
    prev     = 4'h0;
    gid_pend = -1;
    for (int c = 0; c < 600; c++) begin
      if (n == 5 && !busy0) break;
      cycle((c % 3) == 0, (n < 5) ? 4'hF : 4'h0);
      if (gid_pend >= 0) begin
        chk("rr_gid", gid0, 32'(gid_pend));
        gid_pend = -1;
      end
      if (rdy0 != 4'h0) begin
        chk("rr_order", rdy0, (n < 5) ? 32'(1 << order[n]) : 32'h0);
        chk("rr_pulse_width", prev, 4'h0);
        gid_pend = (n < 5) ? order[n] : 0;
        n++;
      end
      prev = rdy0;
    end
    chk("rr_grant_count", n, 5);
    chk("rr_end_busy", busy0, 1'b0);

    // Reset during DATA bit 3 abandons the frame and restores priority to req0.
    do_reset();
    req_data = {8'h00, 8'h00, 8'h5A, 8'hA5};
    cycle(1'b0, 4'b0001);
    chk("mid_rst_grant", rdy0, 4'b0001);
    for (int k = 0; k <= 4; k++) begin
      cycle(1'b1, 4'h0);
      cycle(1'b0, 4'h0);
    end
    chk("mid_rst_bit3", tx0, 1'b0);
    chk("mid_rst_busy_before", busy0, 1'b1);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    @(negedge clk);
    nrst = 1'b1;
    #1;
    chk("mid_rst_tx", tx0, 1'b1);
    chk("mid_rst_busy", busy0, 1'b0);
    chk("mid_rst_gid", gid0, 2'd0);
    chk("mid_rst_done", fd0, 1'b0);
    cycle(1'b0, 4'b0011);
    chk("mid_rst_priority", rdy0, 4'b0001);
    cycle(1'b0, 4'h0);

    // req3 appears mid-frame and withdraws before the stop bit.
    do_reset();
    req_data = {8'hC3, 8'h00, 8'h00, 8'h55};
    cycle(1'b0, 4'b0001);
    chk("wd_grant", rdy0, 4'b0001);
    for (int k = 0; k <= 11; k++) begin
      cycle(1'b1, (k >= 3 && k <= 8) ? 4'b1000 : 4'h0);
      if (k == 11) chk("wd_done", fd0, 1'b1);
      chk("wd_no_ready_tick", rdy0, 4'h0);
      cycle(1'b0, (k >= 3 && k <= 8) ? 4'b1000 : 4'h0);
      chk("wd_no_ready", rdy0, 4'h0);
    end
    cycle(1'b0, 4'h0);
    chk("wd_idle_busy", busy0, 1'b0);
    chk("wd_idle_tx", tx0, 1'b1);
    chk("wd_idle_ready", rdy0, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
